// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared types and defaults for the DDR port arbiter
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] REQ_ROM = 2'd0;
    localparam logic [1:0] REQ_DL  = 2'd1;
    localparam logic [1:0] REQ_SAV = 2'd2;

    localparam logic [24:0] SAV_BASE_DEF   = 25'h1F00000;
    localparam int          STARVE_MAX_DEF = 8;

endpackage

// File: rtl/tog_pending.sv
// rtl/tog_pending.sv - toggle-handshake ack register with pending flag
module tog_pending (
    input  logic clk_sys,
    input  logic reset,
    input  logic req,
    input  logic done,
    output logic ack,
    output logic pending
);

    // Reset copies req so any outstanding request is dropped; done flips ack.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ack <= req;
        end else if (done) begin
            ack <= ~ack;
        end
    end

    assign pending = req ^ ack;

endmodule

// File: rtl/ddr_port_arbiter.sv
// rtl/ddr_port_arbiter.sv - three-way arbiter onto the ddram toggle port
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int              AW         = 25,
    parameter int              DW         = 16,
    parameter logic [AW-1:0]   SAV_BASE   = AW'(SAV_BASE_DEF),
    parameter int              STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          rom_req,
    input  logic [AW-1:0] rom_addr,
    output logic [DW-1:0] rom_dout,
    output logic          rom_ack,
    input  logic          dl_req,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_din,
    output logic          dl_ack,
    input  logic          sav_req,
    input  logic          sav_we,
    input  logic [AW-1:0] sav_addr,
    input  logic [DW-1:0] sav_din,
    output logic [DW-1:0] sav_dout,
    output logic          sav_ack,
    output logic          mem_rd_req,
    input  logic          mem_rd_ack,
    output logic          mem_wr_req,
    input  logic          mem_wr_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    state_t        state;
    logic [1:0]    winner;
    logic          win_wr;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] starve_cnt;

    logic rom_pend, dl_pend, sav_pend;
    logic lower_pend, starve_hit, mem_outstanding;
    logic grant_valid, grant_wr;
    logic [1:0]    grant_idx;
    logic [AW-1:0] grant_addr;
    logic [DW-1:0] grant_din;

    tog_pending u_rom (
        .clk_sys (clk_sys), .reset (reset), .req (rom_req),
        .done    (state == DONE && winner == REQ_ROM),
        .ack     (rom_ack), .pending (rom_pend)
    );

    tog_pending u_dl (
        .clk_sys (clk_sys), .reset (reset), .req (dl_req),
        .done    (state == DONE && winner == REQ_DL),
        .ack     (dl_ack), .pending (dl_pend)
    );

    tog_pending u_sav (
        .clk_sys (clk_sys), .reset (reset), .req (sav_req),
        .done    (state == DONE && winner == REQ_SAV),
        .ack     (sav_ack), .pending (sav_pend)
    );

    assign lower_pend      = dl_pend | sav_pend;
    assign starve_hit      = lower_pend && (starve_cnt == CW'(STARVE_MAX));
    assign mem_outstanding = (mem_rd_req != mem_rd_ack) || (mem_wr_req != mem_wr_ack);

    // Fixed priority ROM > download > save, with ROM skipped once the starvation budget is spent.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = REQ_ROM;
        grant_wr    = 1'b0;
        grant_addr  = rom_addr;
        grant_din   = dl_din;
        if (rom_pend && !starve_hit) begin
            grant_valid = 1'b1;
        end else if (dl_pend) begin
            grant_valid = 1'b1;
            grant_idx   = REQ_DL;
            grant_wr    = 1'b1;
            grant_addr  = dl_addr;
        end else if (sav_pend) begin
            grant_valid = 1'b1;
            grant_idx   = REQ_SAV;
            grant_wr    = sav_we;
            grant_addr  = sav_addr + SAV_BASE;
            grant_din   = sav_din;
        end
    end

    // Transaction sequencer: grant, wait for the ddram ack, return data and ack the winner.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // A transaction already issued to ddram must still be absorbed.
            state      <= (state == WAIT || state == DONE || mem_outstanding) ? DRAIN : IDLE;
            rom_dout   <= '0;
            sav_dout   <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            rd_data    <= '0;
            starve_cnt <= '0;
            winner     <= REQ_ROM;
            win_wr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!lower_pend) begin
                        starve_cnt <= '0;
                    end
                    if (grant_valid) begin
                        winner   <= grant_idx;
                        win_wr   <= grant_wr;
                        mem_addr <= grant_addr;
                        mem_din  <= grant_din;
                        if (grant_wr) begin
                            mem_wr_req <= ~mem_wr_req;
                        end else begin
                            mem_rd_req <= ~mem_rd_req;
                        end
                        if (grant_idx == REQ_ROM && lower_pend) begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end else begin
                            starve_cnt <= '0;
                        end
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (win_wr) begin
                        if (mem_wr_ack == mem_wr_req) begin
                            state <= DONE;
                        end
                    end else if (mem_rd_ack == mem_rd_req) begin
                        rd_data <= mem_dout;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (!win_wr && winner == REQ_ROM) begin
                        rom_dout <= rd_data;
                    end
                    if (!win_wr && winner == REQ_SAV) begin
                        sav_dout <= rd_data;
                    end
                    state <= IDLE;
                end
                default: begin
                    if (!mem_outstanding) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb/tb_ddr_port_arbiter.sv - directed self-checking bench for ddr_port_arbiter
module tb_ddr_port_arbiter;
    import ddr_arb_pkg::*;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        rom_req = 1'b0;
    logic [24:0] rom_addr = '0;
    logic [15:0] rom_dout;
    logic        rom_ack;
    logic        dl_req = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [15:0] dl_din = '0;
    logic        dl_ack;
    logic        sav_req = 1'b0;
    logic        sav_we = 1'b0;
    logic [24:0] sav_addr = '0;
    logic [15:0] sav_din = '0;
    logic [15:0] sav_dout;
    logic        sav_ack;
    logic        mem_rd_req;
    logic        mem_rd_ack = 1'b0;
    logic        mem_wr_req;
    logic        mem_wr_ack = 1'b0;
    logic [24:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout = '0;

    int checks = 0;
    int errors = 0;

    int          rd_lat = 5;
    int          wr_lat = 3;
    bit          rd_hold = 1'b0;
    logic [15:0] rd_val = '0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    ddr_port_arbiter dut (
        .clk_sys (clk_sys), .reset (reset),
        .rom_req (rom_req), .rom_addr (rom_addr), .rom_dout (rom_dout), .rom_ack (rom_ack),
        .dl_req (dl_req), .dl_addr (dl_addr), .dl_din (dl_din), .dl_ack (dl_ack),
        .sav_req (sav_req), .sav_we (sav_we), .sav_addr (sav_addr), .sav_din (sav_din),
        .sav_dout (sav_dout), .sav_ack (sav_ack),
        .mem_rd_req (mem_rd_req), .mem_rd_ack (mem_rd_ack),
        .mem_wr_req (mem_wr_req), .mem_wr_ack (mem_wr_ack),
        .mem_addr (mem_addr), .mem_din (mem_din), .mem_dout (mem_dout)
    );

    always #5 clk_sys = ~clk_sys;

    // ddram model: acks a toggle after a programmable number of cycles
    always @(negedge clk_sys) begin
        if (mem_rd_req != mem_rd_ack) begin
            if (!rd_hold) rd_cnt = rd_cnt + 1;
            if (!rd_hold && rd_cnt >= rd_lat) begin
                mem_dout   = rd_val;
                mem_rd_ack = mem_rd_req;
                rd_cnt     = 0;
            end
        end else begin
            rd_cnt = 0;
        end
        if (mem_wr_req != mem_wr_ack) begin
            wr_cnt = wr_cnt + 1;
            if (wr_cnt >= wr_lat) begin
                mem_wr_ack = mem_wr_req;
                wr_cnt     = 0;
            end
        end else begin
            wr_cnt = 0;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_mem(input bit is_wr, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys);
            #1;
            n++;
            if (is_wr ? (mem_wr_ack == mem_wr_req) : (mem_rd_ack == mem_rd_req)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", dut.state, IDLE); end
        checks++; if (rom_dout !== 16'h0 || sav_dout !== 16'h0) begin errors++; $display("FAIL reset_dout got %h/%h want 0000/0000", rom_dout, sav_dout); end
        checks++; if (mem_addr !== 25'h0 || mem_din !== 16'h0) begin errors++; $display("FAIL reset_mem got %h/%h want 0/0", mem_addr, mem_din); end
        rom_req = 1'b1;
        tick();
        checks++; if (rom_ack !== 1'b1) begin errors++; $display("FAIL reset_ack_copy got %b want 1", rom_ack); end
        reset = 1'b0;
        tick();
        checks++; if (dut.state !== IDLE || rom_ack !== 1'b1) begin errors++; $display("FAIL reset_release got state %0d ack %b want 0 1", dut.state, rom_ack); end
    endtask

    task automatic test_rom_read();
        logic r0, a0;
        int   n;
        bit   ok;
        r0 = mem_rd_req;
        a0 = rom_ack;
        rd_lat = 5; rd_val = 16'hA55A;
        rom_addr = 25'h000100;
        rom_req = ~rom_req;
        tick();
        checks++; if (mem_rd_req !== ~r0 || mem_addr !== 25'h000100) begin errors++; $display("FAIL rom_issue got req %b addr %h want %b 000100", mem_rd_req, mem_addr, ~r0); end
        wait_mem(1'b0, n, ok);
        checks++; if (!ok || n != 5) begin errors++; $display("FAIL rom_mem_latency got ok %0d n %0d want 1 5", ok, n); end
        tick();
        checks++; if (rom_ack !== a0) begin errors++; $display("FAIL rom_ack_early got %b want %b", rom_ack, a0); end
        tick();
        checks++; if (rom_ack !== ~a0 || rom_dout !== 16'hA55A) begin errors++; $display("FAIL rom_done got ack %b dout %h want %b A55A", rom_ack, rom_dout, ~a0); end
    endtask

    task automatic test_dl_write();
        logic r0, w0;
        int   n;
        bit   ok;
        r0 = mem_rd_req;
        w0 = mem_wr_req;
        wr_lat = 3;
        dl_addr = 25'h1234; dl_din = 16'hBEEF;
        dl_req = ~dl_req;
        tick();
        checks++; if (mem_wr_req !== ~w0 || mem_rd_req !== r0) begin errors++; $display("FAIL dl_issue got wr %b rd %b want %b %b", mem_wr_req, mem_rd_req, ~w0, r0); end
        checks++; if (mem_addr !== 25'h1234 || mem_din !== 16'hBEEF) begin errors++; $display("FAIL dl_bus got %h/%h want 1234/BEEF", mem_addr, mem_din); end
        wait_mem(1'b1, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dl_wait got timeout want ack"); end
        tick(); tick();
        checks++; if (dl_ack !== dl_req || rom_dout !== 16'hA55A) begin errors++; $display("FAIL dl_done got ack %b dout %h want %b A55A", dl_ack, rom_dout, dl_req); end
        repeat (5) tick();
        checks++; if (dl_ack !== dl_req) begin errors++; $display("FAIL dl_ack_once got %b want %b", dl_ack, dl_req); end
    endtask

    task automatic test_sav();
        logic r0, w0;
        int   n;
        bit   ok;
        r0 = mem_rd_req;
        rd_lat = 4; rd_val = 16'h1357;
        sav_we = 1'b0; sav_addr = 25'h0200000;
        sav_req = ~sav_req;
        tick();
        checks++; if (mem_rd_req !== ~r0 || mem_addr !== 25'h0100000) begin errors++; $display("FAIL sav_wrap got req %b addr %h want %b 0100000", mem_rd_req, mem_addr, ~r0); end
        wait_mem(1'b0, n, ok);
        tick(); tick();
        checks++; if (!ok || sav_dout !== 16'h1357 || rom_dout !== 16'hA55A || sav_ack !== sav_req) begin
            errors++; $display("FAIL sav_read got ok %0d sav %h rom %h ack %b want 1 1357 A55A %b", ok, sav_dout, rom_dout, sav_ack, sav_req);
        end
        w0 = mem_wr_req;
        sav_we = 1'b1; sav_addr = 25'h10; sav_din = 16'h55AA;
        sav_req = ~sav_req;
        tick();
        checks++; if (mem_wr_req !== ~w0 || mem_addr !== 25'h1F00010 || mem_din !== 16'h55AA) begin
            errors++; $display("FAIL sav_write got wr %b addr %h din %h want %b 1F00010 55AA", mem_wr_req, mem_addr, mem_din, ~w0);
        end
        wait_mem(1'b1, n, ok);
        tick(); tick();
        checks++; if (!ok || sav_ack !== sav_req || sav_dout !== 16'h1357) begin errors++; $display("FAIL sav_write_done got ok %0d ack %b dout %h want 1 %b 1357", ok, sav_ack, sav_dout, sav_req); end
        sav_we = 1'b0;
    endtask

    task automatic test_contention();
        logic [24:0] g[12];
        logic [1:0]  prev;
        int          ng, rom_left, first_sav;
        rd_lat = 2; wr_lat = 2; rd_val = 16'h0F0F;
        rom_addr = 25'h1; dl_addr = 25'h2; sav_addr = 25'h3; sav_we = 1'b0;
        prev = {mem_rd_req, mem_wr_req};
        ng = 0;
        rom_req = ~rom_req; dl_req = ~dl_req; sav_req = ~sav_req;
        for (int i = 0; i < 100 && ng < 3; i++) begin
            tick();
            if ({mem_rd_req, mem_wr_req} != prev) begin g[ng] = mem_addr; ng++; prev = {mem_rd_req, mem_wr_req}; end
        end
        checks++; if (ng != 3 || g[0] !== 25'h1 || g[1] !== 25'h2 || g[2] !== 25'h1F00003) begin
            errors++; $display("FAIL contention_order got n %0d %h %h %h want 3 1 2 1F00003", ng, g[0], g[1], g[2]);
        end
        repeat (10) tick();
        checks++; if (rom_ack !== rom_req || dl_ack !== dl_req || sav_ack !== sav_req) begin errors++; $display("FAIL contention_drain got acks %b%b%b want %b%b%b", rom_ack, dl_ack, sav_ack, rom_req, dl_req, sav_req); end

        // ROM keeps re-requesting while save waits
        prev = {mem_rd_req, mem_wr_req};
        ng = 0; rom_left = 10; first_sav = -1;
        rom_req = ~rom_req; sav_req = ~sav_req;
        for (int i = 0; i < 400 && ng < 12; i++) begin
            tick();
            if ({mem_rd_req, mem_wr_req} != prev) begin
                g[ng] = mem_addr;
                if (mem_addr == 25'h1F00003 && first_sav < 0) first_sav = ng;
                ng++;
                prev = {mem_rd_req, mem_wr_req};
            end
            if (rom_left > 0 && rom_req == rom_ack) begin rom_req = ~rom_req; rom_left--; end
        end
        checks++; if (ng != 12 || first_sav != 8) begin errors++; $display("FAIL starve_guard got grants %0d sav_at %0d want 12 8", ng, first_sav); end
        checks++; if (g[7] !== 25'h1 || g[9] !== 25'h1) begin errors++; $display("FAIL starve_neighbours got %h %h want 1 1", g[7], g[9]); end
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_read();
        int n;
        bit ok;
        rd_hold = 1'b1; rd_lat = 3; rd_val = 16'hDEAD;
        rom_addr = 25'h40;
        rom_req = ~rom_req;
        tick();
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++; if (rom_ack !== rom_req || dut.state !== DRAIN || rom_dout !== 16'h0) begin
            errors++; $display("FAIL midreset got ack %b state %0d dout %h want %b %0d 0000", rom_ack, dut.state, rom_dout, rom_req, DRAIN);
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (dut.state !== DRAIN) begin errors++; $display("FAIL drain_hold got %0d want %0d", dut.state, DRAIN); end
        rd_hold = 1'b0;
        wait_mem(1'b0, n, ok);
        tick();
        checks++; if (!ok || dut.state !== IDLE || rom_dout !== 16'h0 || rom_ack !== rom_req) begin
            errors++; $display("FAIL drain_exit got ok %0d state %0d dout %h ack %b want 1 0 0000 %b", ok, dut.state, rom_dout, rom_ack, rom_req);
        end
        rd_val = 16'h4242; rom_addr = 25'h80;
        rom_req = ~rom_req;
        tick();
        wait_mem(1'b0, n, ok);
        tick(); tick();
        checks++; if (!ok || rom_dout !== 16'h4242 || rom_ack !== rom_req) begin errors++; $display("FAIL post_reset_read got ok %0d dout %h ack %b want 1 4242 %b", ok, rom_dout, rom_ack, rom_req); end
    endtask

    task automatic test_idle();
        logic r0, w0;
        bit   moved, left_idle;
        r0 = mem_rd_req; w0 = mem_wr_req;
        moved = 1'b0; left_idle = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mem_rd_req !== r0 || mem_wr_req !== w0) moved = 1'b1;
            if (dut.state !== IDLE) left_idle = 1'b1;
        end
        checks++; if (moved !== 1'b0) begin errors++; $display("FAIL idle_mem_req got moved %b want 0", moved); end
        checks++; if (left_idle !== 1'b0) begin errors++; $display("FAIL idle_state got left %b want 0", left_idle); end
    endtask

    initial begin
        test_reset();
        test_rom_read();
        test_dl_write();
        test_sav();
        test_contention();
        test_reset_mid_read();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
